conv_mac_pipe: RTL

Pipelined, parametrised fixed-point multiply-accumulate engine for the convolver datapath. Multiplies KERNEL_SIZE² signed weight/pixel lane pairs, reduces the products through a registered adder tree, then rounds, rescales and saturates to one DATA_WIDTH output pixel per accepted window. It is the clocked successor of the combinational per-lane multiplier. It adds configurable fraction width, rounding, saturation with overflow flag, and valid/ready flow control, and sits between the window buffer and the activation stage.

---
 rtl/conv_mac_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined signed fixed-point multiply-accumulate for one
// KERNEL_SIZE x KERNEL_SIZE convolution window. Each window is multiplied
// lane-wise, reduced through a registered adder tree, then rounded, rescaled
// and saturated (or wrapped) to a single DATA_WIDTH output pixel.
// All stages advance in lock step under a single enable, so a downstream
// stall freezes the whole pipe and no window is lost or duplicated.
module conv_mac_pipe #(
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8,
   parameter int KERNEL_SIZE = 5,
   parameter int ROUND       = 1,
   parameter int SATURATE    = 1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [DATA_WIDTH-1:0]                        result,
   output logic                                         overflow
);

   localparam int unsigned N  = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned L  = $clog2(N);
   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned S  = PW + L;

   localparam logic signed [S-1:0] HALF_LSB = {{(S-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
   localparam logic signed [S-1:0] RND_ADD  = (ROUND != 0) ? HALF_LSB : '0;
   localparam logic signed [S-1:0] MAX_VAL  = {{(S-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [S-1:0] MIN_VAL  = {{(S-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   // Number of live nodes at tree level l (level 0 = the N products).
   function automatic int unsigned lvl_cnt(input int unsigned l);
      int unsigned c;
      c = N;
      for (int unsigned i = 0; i < l; i++) c = (c + 1) / 2;
      return c;
   endfunction

   logic                   adv;
   logic signed [PW-1:0]   w_ext   [N];
   logic signed [PW-1:0]   p_ext   [N];
   logic signed [PW-1:0]   prod_q  [N];
   logic signed [S-1:0]    sum_q   [1:L][N];
   // Padded to 2N so the pairwise indices of every level stay in range.
   logic signed [S-1:0]    lvl     [0:L][2*N];
   logic signed [S-1:0]    rs_d;
   logic signed [S-1:0]    rs_q;
   logic                   v_m;
   logic [L:1]             v_t;
   logic                   v_rs;
   logic [DATA_WIDTH-1:0]  low;
   logic [DATA_WIDTH-1:0]  sat_res;
   logic                   sat_ovf;

   // Global lock-step advance and input acceptance.
   always_comb begin
      adv      = !out_valid || out_ready;
      in_ready = adv && !reset;
   end

   // Sign-extend every lane operand to product width.
   always_comb begin
      for (int unsigned j = 0; j < N; j++) begin
         w_ext[j] = {{DATA_WIDTH{weights[j*DATA_WIDTH + DATA_WIDTH - 1]}},
                     weights[j*DATA_WIDTH +: DATA_WIDTH]};
         p_ext[j] = {{DATA_WIDTH{pixel_data[j*DATA_WIDTH + DATA_WIDTH - 1]}},
                     pixel_data[j*DATA_WIDTH +: DATA_WIDTH]};
      end
   end

   // Uniform view of every tree level: level 0 is the sign-extended product row.
   always_comb begin
      for (int unsigned l = 0; l <= L; l++)
         for (int unsigned j = 0; j < 2*N; j++)
            lvl[l][j] = '0;
      for (int unsigned j = 0; j < N; j++)
         lvl[0][j] = {{L{prod_q[j][PW-1]}}, prod_q[j]};
      for (int unsigned l = 1; l <= L; l++)
         for (int unsigned j = 0; j < N; j++)
            lvl[l][j] = sum_q[l][j];
   end

   // Round-half-up offset then arithmetic rescale of the full-precision sum.
   always_comb begin
      rs_d = (lvl[L][0] + RND_ADD) >>> FRAC_BITS;
   end

   // Clamp or wrap the rescaled value to DATA_WIDTH and flag any change.
   always_comb begin
      low     = rs_q[DATA_WIDTH-1:0];
      sat_res = low;
      sat_ovf = 1'b0;
      if (SATURATE != 0) begin
         if (rs_q > MAX_VAL) begin
            sat_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            sat_ovf = 1'b1;
         end else if (rs_q < MIN_VAL) begin
            sat_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sat_ovf = 1'b1;
         end
      end else begin
         sat_ovf = (rs_q != $signed({{(S-DATA_WIDTH){low[DATA_WIDTH-1]}}, low}));
      end
   end

   // Datapath registers: products, adder-tree levels and rescale stage.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int unsigned j = 0; j < N; j++)
            prod_q[j] <= w_ext[j] * p_ext[j];
         for (int unsigned l = 1; l <= L; l++) begin
            for (int unsigned j = 0; j < N; j++) begin
               if (j < lvl_cnt(l)) begin
                  if (2*j + 1 < lvl_cnt(l - 1))
                     sum_q[l][j] <= lvl[l-1][2*j] + lvl[l-1][2*j + 1];
                  else
                     sum_q[l][j] <= lvl[l-1][2*j];
               end else begin
                  sum_q[l][j] <= '0;
               end
            end
         end
         rs_q <= rs_d;
      end
   end

   // Valid shift chain and output register; reset discards in-flight windows.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_m       <= 1'b0;
         v_t       <= '0;
         v_rs      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         overflow  <= 1'b0;
      end else if (adv) begin
         v_m  <= in_valid;
         v_t[1] <= v_m;
         for (int unsigned l = 2; l <= L; l++)
            v_t[l] <= v_t[l-1];
         v_rs      <= v_t[L];
         out_valid <= v_rs;
         if (v_rs) begin
            result   <= sat_res;
            overflow <= sat_ovf;
         end
      end
   end

endmodule
